add_serial_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one `add_serial` 8-bit bit-serial adder between N requesters.
- Accepts operand pairs over valid/ready, drives the adder's `en`/`a`/`b` with the exact pulse timing the adder FSM needs, captures the sum and returns it on a shared response bus tagged with the requester ID.
- Sits between client engines and the single adder instance. The adder's active-high `rst` is driven by `~rst_n` from the same domain.

---
 rtl/add_serial_arb_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/add_serial_arb.sv | 163 ++++++++++++++++
 tb/tb_add_serial_arb.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_serial_arb_pkg.sv
// Shared types and constants for the add_serial round-robin sequencer.
// Imported by add_serial_arb and rr_arbiter.
package add_serial_arb_pkg;

  localparam int DATA_W      = 8;
  localparam int ADD_CYC_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    CAPTURE = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int  N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = W'(idx);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/add_serial_arb.sv
// Shares one bit-serial add_serial adder between N_REQ requesters.
// Optional perf counters: define ADD_SERIAL_ARB_PERF_EN.
module add_serial_arb
  import add_serial_arb_pkg::*;
#(
  parameter int  N_REQ   = 4,
  parameter int  ADD_CYC = ADD_CYC_DEF,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    add_en,
  output logic [DATA_W-1:0]       add_a,
  output logic [DATA_W-1:0]       add_b,
  input  logic [DATA_W-1:0]       add_out,
  output logic                    busy
`ifdef ADD_SERIAL_ARB_PERF_EN
  ,
  output logic [15:0]             perf_ops,
  output logic [15:0]             perf_wait
`endif
);

  localparam int CNT_W = $clog2(ADD_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADD_CYC - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(N_REQ - 1);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   add_a_q, add_a_d;
  logic [DATA_W-1:0]   add_b_q, add_b_d;
  logic [ID_W-1:0]     cur_id_q, cur_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic [DATA_W-1:0]   op_a [N_REQ];
  logic [DATA_W-1:0]   op_b [N_REQ];
  logic [N_REQ-1:0]    gnt;
  logic [ID_W-1:0]     gnt_idx;
  logic                any;

  for (genvar i = 0; i < N_REQ; i++) begin : g_ops
    assign op_a[i] = req_a[i*DATA_W +: DATA_W];
    assign op_b[i] = req_b[i*DATA_W +: DATA_W];
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    cur_id_d    = cur_id_q;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          add_a_d  = op_a[gnt_idx];
          add_b_d  = op_b[gnt_idx];
          cur_id_d = gnt_idx;
          rr_ptr_d = (gnt_idx == ID_LAST) ? '0 : gnt_idx + 1'b1;
          state_d  = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = CAPTURE;
      end
      CAPTURE: begin
        // adder sits in DONE here, so add_out is the final sum
        rsp_data_d  = add_out;
        rsp_id_d    = cur_id_q;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      cur_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      cur_id_q    <= cur_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // en in CAPTURE also walks the adder from DONE back to idle
  assign req_ready = (state_q == IDLE) ? gnt : '0;
  assign add_en    = (state_q == START) || (state_q == CAPTURE);
  assign busy      = (state_q != IDLE);
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

`ifdef ADD_SERIAL_ARB_PERF_EN
  logic [15:0] perf_ops_q, perf_ops_d;
  logic [15:0] perf_wait_q, perf_wait_d;

  always_comb begin
    perf_ops_d  = perf_ops_q;
    perf_wait_d = perf_wait_q;
    if (rsp_valid_q && (perf_ops_q != 16'hFFFF))
      perf_ops_d = perf_ops_q + 16'd1;
    if ((|req_valid) && !(|req_ready) && (perf_wait_q != 16'hFFFF))
      perf_wait_d = perf_wait_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops_q  <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_ops_q  <= perf_ops_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_ops  = perf_ops_q;
  assign perf_wait = perf_wait_q;
`endif

endmodule

// File: tb/tb_add_serial_arb.sv
// Bench for add_serial_arb: serial adder model, timeline reference model,
// directed cases and randomized traffic.
module tb_add_serial_arb;

  localparam int N  = 4;
  localparam int AC = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_data;
  logic           add_en;
  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic [7:0]     add_out;
  logic           busy;
`ifdef ADD_SERIAL_ARB_PERF_EN
  logic [15:0]    perf_ops;
  logic [15:0]    perf_wait;
`endif

  add_serial_arb #(.N_REQ(N), .ADD_CYC(AC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .busy      (busy)
`ifdef ADD_SERIAL_ARB_PERF_EN
    ,
    .perf_ops  (perf_ops),
    .perf_wait (perf_wait)
`endif
  );

  always #5 clk = ~clk;

  // serial adder: idle -> en loads -> AC add cycles -> done (en returns idle)
  int         ast;
  int         acnt;
  logic [7:0] asum;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ast  <= 0;
      acnt <= 0;
      asum <= 8'h00;
    end else begin
      case (ast)
        0: if (add_en) begin
          ast  <= 1;
          acnt <= 0;
          asum <= add_a + add_b;
        end
        1: begin
          acnt <= acnt + 1;
          if (acnt == AC - 1) ast <= 2;
        end
        default: if (add_en) ast <= 0;
      endcase
    end
  end

  assign add_out = (ast == 2) ? asum : ~asum;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference model: phase 0 idle, 1..10 = cycles after accept
  int         cyc = 0;
  int         ph = 0;
  int         rr = 0;
  int         m_id = 0;
  logic [7:0] m_sum = 8'h00;
  bit         exp_rv = 0;
  int         exp_id = 0;
  logic [7:0] exp_data = 8'h00;
  logic [N-1:0] m_gnt = '0;
  int         acc_q[$];
  int         rid_q[$];
  logic [7:0] rdat_q[$];
  int         rcyc_q[$];
`ifdef ADD_SERIAL_ARB_PERF_EN
  int         m_ops = 0;
  int         m_wait = 0;
`endif

  always @(negedge clk) begin
    logic [N-1:0] er;
    int w;
    int j;
    cyc++;
    if (!rst_n) begin
      ph = 0; rr = 0; exp_rv = 0; exp_id = 0; exp_data = 8'h00;
      m_gnt = '0;
      acc_q.delete();
`ifdef ADD_SERIAL_ARB_PERF_EN
      m_ops = 0; m_wait = 0;
`endif
    end
    er = '0;
    w = -1;
    if (rst_n && ph == 0) begin
      for (int k = 0; k < N; k++) begin
        j = (rr + k) % N;
        if (w < 0 && req_valid[j]) w = j;
      end
      if (w >= 0) er[w] = 1'b1;
    end
    chk("req_ready", req_ready, er);
    chk("busy", busy, ph != 0);
    chk("add_en", add_en, ph == 1 || ph == 10);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_id", rsp_id, exp_id);
    chk("rsp_data", rsp_data, exp_data);
`ifdef ADD_SERIAL_ARB_PERF_EN
    chk("perf_ops", perf_ops, m_ops);
    chk("perf_wait", perf_wait, m_wait);
`endif
    if (rsp_valid === 1'b1) begin
      rid_q.push_back(int'(rsp_id));
      rdat_q.push_back(rsp_data);
      rcyc_q.push_back(cyc);
    end
    if (rst_n) begin
`ifdef ADD_SERIAL_ARB_PERF_EN
      if (exp_rv) m_ops++;
      if (req_valid != '0 && er == '0) m_wait++;
`endif
      exp_rv = (ph == 10);
      if (ph == 10) begin
        exp_id = m_id;
        exp_data = m_sum;
      end
      m_gnt = er;
      if (ph == 0 && w >= 0) begin
        ph = 1;
        m_id = w;
        m_sum = 8'((req_a[8*w +: 8] + req_b[8*w +: 8]) % 256);
        rr = (w + 1) % N;
        acc_q.push_back(cyc);
      end else if (ph == 10) begin
        ph = 0;
      end else if (ph != 0) begin
        ph++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    rid_q.delete();
    rdat_q.delete();
    rcyc_q.delete();
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    tick();
  endtask

  task automatic issue(int i, logic [7:0] a, logic [7:0] b);
    bit g;
    g = 0;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 60; t++) begin
      tick();
      if (m_gnt[i]) begin
        g = 1;
        break;
      end
    end
    req_valid[i] = 1'b0;
    chk("grant_timeout", g, 1);
  endtask

  task automatic wait_rsp(output logic [7:0] d, output int id, output int lat);
    bit got;
    int c;
    for (int t = 0; t < 40; t++) begin
      if (rid_q.size() > 0) break;
      tick();
    end
    got = rid_q.size() > 0;
    chk("rsp_timeout", got, 1);
    d = 8'hxx; id = -1; lat = -1;
    if (got) begin
      d = rdat_q.pop_front();
      id = rid_q.pop_front();
      c = rcyc_q.pop_front();
      if (acc_q.size() > 0) lat = c - acc_q.pop_front();
    end
  endtask

  initial begin
    logic [7:0] d;
    int id;
    int lat;
    int base;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    issue(2, 8'h35, 8'h4A);
    wait_rsp(d, id, lat);
    chk("single_data", d, 8'h7F);
    chk("single_id", id, 2);
    chk("single_lat", lat, 11);

    issue(0, 8'hFF, 8'h02);
    wait_rsp(d, id, lat);
    chk("ovf_ff_02", d, 8'h01);
    issue(0, 8'h80, 8'h80);
    wait_rsp(d, id, lat);
    chk("ovf_80_80", d, 8'h00);

    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = 8'(i + 1);
      req_b[8*i +: 8] = 8'(16 * i);
    end
    req_valid = '1;
    for (int t = 0; t < 80; t++) begin
      if (rid_q.size() >= 5) break;
      tick();
    end
    chk("fair_count", rid_q.size() >= 5, 1);
    if (rid_q.size() >= 5) begin
      for (int r = 0; r < 5; r++) begin
        chk("fair_id", rid_q[r], r % 4);
        if (r > 0) chk("fair_gap", rcyc_q[r] - rcyc_q[r-1], 11);
      end
    end

    do_reset();
    issue(0, 8'h01, 8'h02);
    wait_rsp(d, id, lat);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (m_gnt[0]) req_valid[0] = 1'b0;
      if (m_gnt[3]) req_valid[3] = 1'b0;
      if (rid_q.size() >= 2) break;
    end
    chk("skip_count", rid_q.size() >= 2, 1);
    if (rid_q.size() >= 2) begin
      chk("skip_first", rid_q[0], 3);
      chk("skip_wrap", rid_q[1], 0);
    end
    req_valid = '0;
    tick();
    clear_logs();

    issue(1, 8'h03, 8'h04);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    repeat (15) tick();
    chk("rst_no_rsp", rid_q.size(), 0);
    issue(1, 8'h01, 8'h01);
    wait_rsp(d, id, lat);
    chk("rst_after_data", d, 8'h02);
    chk("rst_after_lat", lat, 11);

`ifdef ADD_SERIAL_ARB_PERF_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      issue(0, 8'(k), 8'(k));
      wait_rsp(d, id, lat);
    end
    chk("perf_ops_5", perf_ops, 5);
    issue(0, 8'h10, 8'h20);
    base = int'(perf_wait);
    req_valid[1] = 1'b1;
    repeat (7) tick();
    req_valid[1] = 1'b0;
    wait_rsp(d, id, lat);
    chk("perf_wait_7", int'(perf_wait) - base, 7);
`else
    base = 0;
`endif

    clear_logs();
    for (int t = 0; t < 1500; t++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && m_gnt[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[8*i +: 8] = 8'($urandom);
          req_b[8*i +: 8] = 8'($urandom);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req_a[8*i +: 8] = 8'($urandom);
          req_b[8*i +: 8] = 8'($urandom);
          req_valid[i] = 1'b1;
        end
      end
    end
    req_valid = '0;
    repeat (15) tick();
    chk("random_rsps_seen", rid_q.size() > 20, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
